// File: rtl/gate_sequencer_pkg.sv
// gate_sequencer_pkg -- shared definitions for the gate sequencer.
//   * gate-code constants (000 = identity ... 111)
//   * sequencer FSM state enum (ST_ERR exists only with SEQ_TIMEOUT_EN)
//   * default buffer depth and controller timeout
// Optional feature macro: SEQ_TIMEOUT_EN (adds the timeout/ERR path).
package gate_sequencer_pkg;

  localparam int GATE_W                 = 3;
  localparam int DEFAULT_DEPTH          = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 2048;

  // Gate codes understood by the controller. Identity is retired locally
  // and never sent to the controller.
  localparam logic [GATE_W-1:0] GATE_IDENTITY = 3'b000;
  localparam logic [GATE_W-1:0] GATE_X        = 3'b001;
  localparam logic [GATE_W-1:0] GATE_Y        = 3'b010;
  localparam logic [GATE_W-1:0] GATE_Z        = 3'b011;
  localparam logic [GATE_W-1:0] GATE_H        = 3'b100;
  localparam logic [GATE_W-1:0] GATE_S        = 3'b101;
  localparam logic [GATE_W-1:0] GATE_T        = 3'b110;
  localparam logic [GATE_W-1:0] GATE_CNOT     = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
`ifdef SEQ_TIMEOUT_EN
    , ST_ERR
`endif
  } seq_state_e;

endpackage

// File: rtl/gate_fifo.sv
// gate_fifo -- synchronous show-ahead program buffer for gate codes.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   flush_i            empty the buffer (any same-cycle write is discarded)
//   wr_en_i / wr_data_i  push request and gate code
//   rd_en_i            pop request (ignored when empty)
//   rd_data_o          head entry, valid whenever empty_o is 0
//   full_o / empty_o   occupancy flags
//   drop_o             a push was refused because the buffer was full
// A push is accepted while full if a pop happens in the same cycle.
module gate_fifo
  import gate_sequencer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [GATE_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [GATE_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [GATE_W-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic              do_pop;
  logic              do_push;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = rd_en_i && !empty_o && !flush_i;
  assign do_push = wr_en_i && !flush_i && (!full_o || do_pop);
  assign drop_o  = wr_en_i && !flush_i && full_o && !do_pop;

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/gate_sequencer.sv
// gate_sequencer -- runs a buffered program of gate codes against an
// external gate controller and captures the resulting amplitudes.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   prog_wr_en, prog_wr_gate      host program writes
//   prog_full, prog_overflow      buffer full; sticky dropped-write flag
//   start, abort                  run / cancel pulses
//   cmd_gate, cmd_execute         command to the controller
//   gate_busy                     controller executing
//   display_alpha, display_beta   controller amplitude monitors
//   result_alpha, result_beta     amplitudes captured after each gate
//   seq_busy, seq_done, seq_err   running; completion pulse; sticky error
//   ops_count                     gates retired in the current run
// Optional feature macro: SEQ_TIMEOUT_EN bounds WAIT_ACK/WAIT_DONE by
// TIMEOUT_CYCLES and adds the ERR state; otherwise the waits are unbounded.
module gate_sequencer
  import gate_sequencer_pkg::*;
#(
  parameter int DEPTH          = DEFAULT_DEPTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_wr_en,
  input  logic [GATE_W-1:0] prog_wr_gate,
  output logic              prog_full,
  output logic              prog_overflow,
  input  logic              start,
  input  logic              abort,
  output logic [GATE_W-1:0] cmd_gate,
  output logic              cmd_execute,
  input  logic              gate_busy,
  input  logic [31:0]       display_alpha,
  input  logic [31:0]       display_beta,
  output logic [31:0]       result_alpha,
  output logic [31:0]       result_beta,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_err,
  output logic [7:0]        ops_count
);

  seq_state_e        state_q;
  logic [GATE_W-1:0] cmd_gate_q;
  logic              cmd_execute_q;
  logic              seq_done_q;
  logic              overflow_q;
  logic [31:0]       result_alpha_q;
  logic [31:0]       result_beta_q;
  logic [7:0]        ops_count_q;
  logic [7:0]        ops_count_d;

  logic [GATE_W-1:0] fifo_head;
  logic              fifo_empty;
  logic              fifo_drop;
  logic              fifo_pop;
  logic              fifo_flush;
  logic              start_accepted;

  assign ops_count_d    = ops_count_q + 8'd1;
  assign start_accepted = start && !abort && (state_q == ST_IDLE);
  assign fifo_pop       = (state_q == ST_FETCH) && !fifo_empty && !abort;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          tmo_expired;
  logic          seq_err_q;

  // Counter starts at 0 on entry, so the limit is hit on the
  // TIMEOUT_CYCLES-th cycle spent in the wait state.
  assign tmo_expired = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign fifo_flush  = abort || (state_q == ST_ERR);
  assign seq_err     = seq_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign fifo_flush     = abort;
  assign seq_err        = 1'b0;
`endif

  gate_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (fifo_flush),
    .wr_en_i   (prog_wr_en),
    .wr_data_i (prog_wr_gate),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_head),
    .full_o    (prog_full),
    .empty_o   (fifo_empty),
    .drop_o    (fifo_drop)
  );

  // cmd_execute and seq_done are raised on the transition into ISSUE/DONE
  // so each is high for exactly the one cycle spent in that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cmd_gate_q     <= GATE_IDENTITY;
      cmd_execute_q  <= 1'b0;
      seq_done_q     <= 1'b0;
      result_alpha_q <= '0;
      result_beta_q  <= '0;
      ops_count_q    <= '0;
`ifdef SEQ_TIMEOUT_EN
      tmo_q          <= '0;
      seq_err_q      <= 1'b0;
`endif
    end else if (abort) begin
      state_q       <= ST_IDLE;
      cmd_execute_q <= 1'b0;
      seq_done_q    <= 1'b0;
    end else begin
      cmd_execute_q <= 1'b0;
      seq_done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_FETCH;
            ops_count_q <= '0;
`ifdef SEQ_TIMEOUT_EN
            seq_err_q   <= 1'b0;
`endif
          end
        end
        ST_FETCH: begin
          if (fifo_empty) begin
            state_q    <= ST_DONE;
            seq_done_q <= 1'b1;
          end else if (fifo_head == GATE_IDENTITY) begin
            ops_count_q <= ops_count_d;
          end else begin
            state_q       <= ST_ISSUE;
            cmd_gate_q    <= fifo_head;
            cmd_execute_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT_ACK;
`ifdef SEQ_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        ST_WAIT_ACK: begin
          if (gate_busy) begin
            state_q <= ST_WAIT_DONE;
`ifdef SEQ_TIMEOUT_EN
            tmo_q   <= '0;
          end else if (tmo_expired) begin
            state_q   <= ST_ERR;
            seq_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
`endif
          end
        end
        ST_WAIT_DONE: begin
          if (!gate_busy) begin
            state_q <= ST_SETTLE;
`ifdef SEQ_TIMEOUT_EN
          end else if (tmo_expired) begin
            state_q   <= ST_ERR;
            seq_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
`endif
          end
        end
        // The controller's display lags busy by a register stage.
        ST_SETTLE: state_q <= ST_CAPTURE;
        ST_CAPTURE: begin
          result_alpha_q <= display_alpha;
          result_beta_q  <= display_beta;
          ops_count_q    <= ops_count_d;
          if (fifo_empty) begin
            state_q    <= ST_DONE;
            seq_done_q <= 1'b1;
          end else begin
            state_q <= ST_FETCH;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
`ifdef SEQ_TIMEOUT_EN
        ST_ERR:  state_q <= ST_IDLE;
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Drop flag: a drop in the same cycle as an accepted start still sets it.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (start_accepted) begin
      overflow_q <= fifo_drop;
    end else if (fifo_drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign prog_overflow = overflow_q;
  assign cmd_gate      = cmd_gate_q;
  assign cmd_execute   = cmd_execute_q;
  assign seq_done      = seq_done_q;
  assign result_alpha  = result_alpha_q;
  assign result_beta   = result_beta_q;
  assign ops_count     = ops_count_q;
  assign seq_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer with a behavioural gate controller.
module tb_gate_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        prog_wr_en = 1'b0;
  logic [2:0]  prog_wr_gate = 3'b000;
  logic        prog_full, prog_overflow;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  cmd_gate;
  logic        cmd_execute;
  logic        gate_busy = 1'b0;
  logic [31:0] display_alpha = 32'h0;
  logic [31:0] display_beta = 32'h0;
  logic [31:0] result_alpha, result_beta;
  logic        seq_busy, seq_done, seq_err;
  logic [7:0]  ops_count;

  int n_cmp = 0;
  int n_fail = 0;

  gate_sequencer #(.DEPTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .prog_wr_en    (prog_wr_en),
    .prog_wr_gate  (prog_wr_gate),
    .prog_full     (prog_full),
    .prog_overflow (prog_overflow),
    .start         (start),
    .abort         (abort),
    .cmd_gate      (cmd_gate),
    .cmd_execute   (cmd_execute),
    .gate_busy     (gate_busy),
    .display_alpha (display_alpha),
    .display_beta  (display_beta),
    .result_alpha  (result_alpha),
    .result_beta   (result_beta),
    .seq_busy      (seq_busy),
    .seq_done      (seq_done),
    .seq_err       (seq_err),
    .ops_count     (ops_count)
  );

  always #5 clk = ~clk;

  // Controller model, evaluated mid-cycle: busy rises the cycle after
  // cmd_execute, stays up 10 cycles, display follows 1 cycle after busy falls.
  logic [2:0] exec_q[$];
  int         done_cnt = 0;
  int         busy_cnt = 0;
  int         disp_cnt = 0;
  bit         pend = 0;
  bit         hang = 0;
  logic [2:0] pend_gate = 3'b000;
  logic [2:0] cur_gate = 3'b000;

  always @(negedge clk) begin
    if (disp_cnt > 0) begin
      disp_cnt--;
      if (disp_cnt == 0) begin
        display_alpha = 32'hA5A5_0000 | 32'(cur_gate);
        display_beta  = 32'h1234_0000 + 3 * 32'(cur_gate);
      end
    end
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        gate_busy = 1'b0;
        disp_cnt  = 1;
      end
    end
    if (pend) begin
      pend      = 0;
      gate_busy = 1'b1;
      busy_cnt  = 10;
      cur_gate  = pend_gate;
    end
    if (cmd_execute === 1'b1) begin
      exec_q.push_back(cmd_gate);
      if (!hang) begin
        pend      = 1;
        pend_gate = cmd_gate;
      end
    end
    if (seq_done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_gate(input logic [2:0] g);
    prog_wr_en   = 1'b1;
    prog_wr_gate = g;
    tick();
    prog_wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (seq_busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(seq_busy), 32'h0);
  endtask

  task automatic wait_exec(input string tag, input int budget);
    int n = 0;
    while (cmd_execute !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(cmd_execute), 32'h1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " cmd_gate"},      32'(cmd_gate), 32'h0);
    check({tag, " cmd_execute"},   32'(cmd_execute), 32'h0);
    check({tag, " result_alpha"},  result_alpha, 32'h0);
    check({tag, " result_beta"},   result_beta, 32'h0);
    check({tag, " ops_count"},     32'(ops_count), 32'h0);
    check({tag, " seq_busy"},      32'(seq_busy), 32'h0);
    check({tag, " seq_done"},      32'(seq_done), 32'h0);
    check({tag, " seq_err"},       32'(seq_err), 32'h0);
    check({tag, " prog_full"},     32'(prog_full), 32'h0);
    check({tag, " prog_overflow"}, 32'(prog_overflow), 32'h0);
  endtask

  initial begin
    int e0;
    int d0;

    // Reset state
    tick();
    tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();
    $display("step reset: done");

    // Three gates in order
    e0 = exec_q.size(); d0 = done_cnt;
    write_gate(3'b001); write_gate(3'b010); write_gate(3'b011);
    pulse_start();
    check("run3 busy", 32'(seq_busy), 32'h1);
    wait_idle("run3 finish", 500);
    check("run3 exec count", 32'(exec_q.size() - e0), 32'd3);
    if (exec_q.size() - e0 == 3) begin
      check("run3 gate0", 32'(exec_q[e0]),     32'h1);
      check("run3 gate1", 32'(exec_q[e0 + 1]), 32'h2);
      check("run3 gate2", 32'(exec_q[e0 + 2]), 32'h3);
    end
    check("run3 ops_count", 32'(ops_count), 32'd3);
    check("run3 result_alpha", result_alpha, 32'hA5A5_0003);
    check("run3 result_beta", result_beta, 32'h1234_0009);
    check("run3 done pulses", 32'(done_cnt - d0), 32'd1);
    check("run3 cmd_gate held", 32'(cmd_gate), 32'h3);
    $display("step run3: ops=%0d alpha=%0h", ops_count, result_alpha);

    // Identity retired without issue
    e0 = exec_q.size(); d0 = done_cnt;
    write_gate(3'b000); write_gate(3'b001);
    pulse_start();
    check("ident ops cleared", 32'(ops_count), 32'd0);
    wait_idle("ident finish", 500);
    check("ident exec count", 32'(exec_q.size() - e0), 32'd1);
    if (exec_q.size() - e0 == 1) check("ident gate", 32'(exec_q[e0]), 32'h1);
    check("ident ops_count", 32'(ops_count), 32'd2);
    check("ident result_alpha", result_alpha, 32'hA5A5_0001);
    check("ident done pulses", 32'(done_cnt - d0), 32'd1);
    $display("step identity: ops=%0d", ops_count);

    // Overflow: 17 writes into 16 entries
    e0 = exec_q.size(); d0 = done_cnt;
    for (int i = 0; i < 16; i++) write_gate(3'((i % 7) + 1));
    check("fill full", 32'(prog_full), 32'h1);
    check("fill no overflow", 32'(prog_overflow), 32'h0);
    write_gate(3'b111);
    check("over full", 32'(prog_full), 32'h1);
    check("over overflow", 32'(prog_overflow), 32'h1);
    pulse_start();
    check("over cleared by start", 32'(prog_overflow), 32'h0);
    wait_idle("over finish", 2000);
    check("over exec count", 32'(exec_q.size() - e0), 32'd16);
    check("over ops_count", 32'(ops_count), 32'd16);
    check("over result_alpha", result_alpha, 32'hA5A5_0002);
    check("over result_beta", result_beta, 32'h1234_0006);
    check("over done pulses", 32'(done_cnt - d0), 32'd1);
    check("over empty after", 32'(prog_full), 32'h0);
    $display("step overflow: ops=%0d", ops_count);

    // Abort during WAIT_DONE of first of three gates
    e0 = exec_q.size(); d0 = done_cnt;
    write_gate(3'b100); write_gate(3'b101); write_gate(3'b110);
    pulse_start();
    wait_exec("abort issue seen", 50);
    repeat (4) tick();
    check("abort pre busy", 32'(seq_busy), 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort idle", 32'(seq_busy), 32'h0);
    check("abort cmd_execute", 32'(cmd_execute), 32'h0);
    repeat (20) tick();
    check("abort exec count", 32'(exec_q.size() - e0), 32'd1);
    check("abort no done", 32'(done_cnt - d0), 32'd0);
    check("abort result_alpha", result_alpha, 32'hA5A5_0002);
    check("abort result_beta", result_beta, 32'h1234_0006);
    // Buffer must be empty: a fresh run finishes immediately.
    pulse_start();
    wait_idle("abort rerun finish", 20);
    check("abort rerun exec", 32'(exec_q.size() - e0), 32'd1);
    check("abort rerun ops", 32'(ops_count), 32'd0);
    check("abort rerun done", 32'(done_cnt - d0), 32'd1);
    $display("step abort: ops=%0d alpha=%0h", ops_count, result_alpha);

`ifdef SEQ_TIMEOUT_EN
    // Controller never acknowledges
    hang = 1;
    write_gate(3'b001);
    write_gate(3'b010);
    pulse_start();
    repeat (9) tick();
    check("tmo before limit", 32'(seq_err), 32'h0);
    tick();
    check("tmo err set", 32'(seq_err), 32'h1);
    check("tmo err busy", 32'(seq_busy), 32'h1);
    tick();
    check("tmo idle", 32'(seq_busy), 32'h0);
    check("tmo err sticky", 32'(seq_err), 32'h1);
    hang = 0;
    d0 = done_cnt;
    pulse_start();
    check("tmo err cleared", 32'(seq_err), 32'h0);
    wait_idle("tmo rerun finish", 20);
    check("tmo flushed", 32'(ops_count), 32'd0);
    check("tmo rerun done", 32'(done_cnt - d0), 32'd1);
    $display("step timeout: err=%0d", seq_err);
`endif

    // Reset mid-run
    e0 = exec_q.size();
    write_gate(3'b001); write_gate(3'b010);
    pulse_start();
    wait_exec("rst issue seen", 50);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_reset_values("midreset");
    reset = 1'b0;
    repeat (30) tick();
    check("midreset exec count", 32'(exec_q.size() - e0), 32'd1);
    check("midreset still idle", 32'(seq_busy), 32'h0);
    $display("step midreset: exec=%0d", exec_q.size() - e0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_sequencer.md
GATE_SEQUENCER -- requirements
Module: gate_sequencer

Interface
REQ-001 Parameter DEPTH, 16, program buffer entries (power of two).
REQ-002 Parameter TIMEOUT_CYCLES, 2048, cycle limit on controller ack and busy.
REQ-003 clk  input  1  system clock; all logic is rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 prog_wr_en / prog_wr_gate  input  1/3  host program write strobe and gate code.
REQ-006 prog_full / prog_overflow  output  1/1  buffer full; sticky write-dropped flag.
REQ-007 start / abort  input  1/1  single-cycle run and cancel pulses.
REQ-008 cmd_gate / cmd_execute  output  3/1  command to the gate controller.
REQ-009 gate_busy  input  1  controller executing.
REQ-010 display_alpha / display_beta  input  32/32  controller amplitude monitors.
REQ-011 result_alpha / result_beta  output  32/32  amplitudes captured after the last gate.
REQ-012 seq_busy / seq_done / seq_err  output  1/1/1  running; one-cycle completion pulse; sticky error.
REQ-013 ops_count  output  8  gates retired in the current run.

Function
REQ-014 The FSM SHALL have the states IDLE, FETCH, ISSUE, WAIT_ACK, WAIT_DONE, SETTLE, CAPTURE, DONE and ERR.
REQ-015 IDLE+start SHALL go to FETCH, clearing ops_count; an empty buffer SHALL go FETCH->DONE with ops_count=0.
REQ-016 FETCH SHALL pop one entry; gate 000 SHALL be retired without issue (ops_count+1, back to FETCH); other codes SHALL go to ISSUE.
REQ-017 ISSUE SHALL assert cmd_execute for exactly one cycle with cmd_gate=popped code, then go to WAIT_ACK.
REQ-018 cmd_gate SHALL hold its value outside ISSUE, and cmd_execute SHALL be 0 in every other state.
REQ-019 WAIT_ACK SHALL go to WAIT_DONE on the first cycle gate_busy=1.
REQ-020 WAIT_DONE SHALL go to SETTLE on the first cycle gate_busy=0.
REQ-021 SETTLE SHALL last 1 cycle, covering the controller's registered display lag; CAPTURE SHALL then register display_alpha/beta into result_alpha/beta and increment ops_count.
REQ-022 After CAPTURE, a non-empty buffer SHALL go to FETCH, otherwise DONE.
REQ-023 DONE SHALL pulse seq_done for 1 cycle, then go to IDLE.
REQ-024 seq_busy SHALL be 1 in every state except IDLE.
REQ-025 ops_count SHALL wrap modulo 256.
REQ-026 A write SHALL be accepted in any state when the buffer is not full or a pop occurs in the same cycle; otherwise it SHALL be dropped and prog_overflow set.
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 abort SHALL take priority over all other events: flush the buffer, return to IDLE next cycle, leave result_* unchanged and produce no seq_done.
REQ-029 prog_overflow and seq_err SHALL clear only on start accepted in IDLE, or on reset.

Reset
REQ-030 Reset SHALL put the FSM in IDLE and empty the buffer.
REQ-031 Reset SHALL drive cmd_gate=000, cmd_execute=0, result_alpha=result_beta=0, ops_count=0, and seq_busy, seq_done, seq_err, prog_full and prog_overflow all 0.
REQ-032 Reset mid-run SHALL take effect at the next edge and issue no further commands.

Configuration
REQ-033 With SEQ_TIMEOUT_EN defined, a counter SHALL run in WAIT_ACK and WAIT_DONE.
REQ-034 With SEQ_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES in either state SHALL go to ERR, set seq_err, flush the buffer, and return to IDLE next cycle.
REQ-035 Without SEQ_TIMEOUT_EN, there SHALL be no counter and no ERR state, seq_err SHALL be tied 0, and the waits SHALL be unbounded.

Structure
REQ-036 A shared package SHALL hold the gate-code constants (000 identity … 111), the FSM state enum and the default DEPTH/TIMEOUT_CYCLES.
REQ-037 The program buffer SHALL be a sub-module gate_fifo: synchronous, show-ahead, with full/empty flags.

Verification
REQ-038 Bench model: a controller goes busy 1 cycle after cmd_execute, stays busy 10 cycles, and updates display 1 cycle after busy falls.
REQ-039 Scenario: write 001,010,011, start -> three cmd_execute pulses in order, ops_count=3, result matches the model's final display, one seq_done.
REQ-040 Scenario: write 000,001, start -> one cmd_execute (gate 001), ops_count=2.
REQ-041 Scenario: write 17 entries with DEPTH=16 -> prog_full after the 16th, prog_overflow=1, 16 gates run.
REQ-042 Scenario: abort in WAIT_DONE of gate 1 of 3 -> IDLE next cycle, buffer empty, no seq_done, result unchanged.
REQ-043 Scenario (SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8): model never raises gate_busy -> seq_err=1 after 8 WAIT_ACK cycles, then IDLE.
REQ-044 Scenario: reset asserted mid-run -> all outputs at reset values on the next cycle, no further cmd_execute.
